// File: rtl/core_input_sched_pkg.sv
// rtl/core_input_sched_pkg.sv - shared widths, defaults and FSM encoding for the input scheduler
package core_input_sched_pkg;

    // blk_op is BLK_OP_MSB+1 bits wide
    localparam int BLK_OP_MSB     = 1;
    localparam int SEQ_PERIOD_DEF = 176;
    localparam int BLK_WORDS      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_LOAD   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/slot_rr_pick.sv
// rtl/slot_rr_pick.sv - combinational round-robin search for a free core input slot
//
// Ports:
//   core_ready_i  per-core ready nibbles, bit index {ctx,seq}, core i at [4i+3:4i]
//   rr_ptr_i      core the search starts from
//   found_o       some core has a free slot
//   core_o        first core at or after rr_ptr_i (mod N_CORES) with a free slot
//   ctx_o, seq_o  lowest free {ctx,seq} slot within that core
module slot_rr_pick #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [4*N_CORES-1:0] core_ready_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     core_o,
    output logic                 ctx_o,
    output logic                 seq_o
);

    logic [3:0]   rdy [N_CORES];
    logic [IDX_W:0] cand;

    for (genvar g = 0; g < N_CORES; g++) begin : g_split
        assign rdy[g] = core_ready_i[4*g +: 4];
    end

    always_comb begin
        found_o = 1'b0;
        core_o  = '0;
        ctx_o   = 1'b0;
        seq_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_CORES; k++) begin
            // one extra bit so rr_ptr + k can exceed N_CORES-1 before wrapping
            cand = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_CORES)) begin
                cand = cand - (IDX_W+1)'(N_CORES);
            end
            if (!found_o && (rdy[cand[IDX_W-1:0]] != 4'b0000)) begin
                found_o = 1'b1;
                core_o  = cand[IDX_W-1:0];
                if (rdy[cand[IDX_W-1:0]][0]) begin
                    ctx_o = 1'b0; seq_o = 1'b0;
                end else if (rdy[cand[IDX_W-1:0]][1]) begin
                    ctx_o = 1'b0; seq_o = 1'b1;
                end else if (rdy[cand[IDX_W-1:0]][2]) begin
                    ctx_o = 1'b1; seq_o = 1'b0;
                end else begin
                    ctx_o = 1'b1; seq_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/core_input_sched.sv
// rtl/core_input_sched.sv - sync generator and block dispatcher for an array of sha512 cores
//
// Ports:
//   CLK, rst_n                 clock, synchronous active-low reset
//   start, ctx_num, seq_num    registered sync broadcast to all cores
//   in_valid/in_ready/in_data  upstream 64-bit word stream, word 0 first
//   in_blk_op, in_last         block op and end marker, meaningful on word 15
//   core_ready                 per-core free-slot nibbles {ctx,seq}
//   core_wr_en ... core_set_rdy  write port broadcast, one-hot core select
//   err_framing                sticky in_last misplacement flag
//   stat_blocks                dispatched block count
// Build option: SCHED_STAT_EN enables the stat_blocks counter; otherwise it reads 0.
module core_input_sched
    import core_input_sched_pkg::*;
#(
    parameter int N_CORES    = 4,
    parameter int SEQ_PERIOD = SEQ_PERIOD_DEF
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    output logic                  start,
    output logic                  ctx_num,
    output logic                  seq_num,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [63:0]           in_data,
    input  logic [BLK_OP_MSB:0]   in_blk_op,
    input  logic                  in_last,
    input  logic [4*N_CORES-1:0]  core_ready,
    output logic [N_CORES-1:0]    core_wr_en,
    output logic [63:0]           core_din,
    output logic [3:0]            core_wr_addr,
    output logic [BLK_OP_MSB:0]   core_blk_op,
    output logic                  core_ctx,
    output logic                  core_seq,
    output logic                  core_set_rdy,
    output logic                  err_framing,
    output logic [31:0]           stat_blocks
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int CNT_W = $clog2(SEQ_PERIOD);

    // ---------------- sequencer ----------------
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic             seq_bit_q;
    logic             start_q, ctx_num_q, seq_num_q;
    logic             seq_wrap;

    assign seq_wrap  = (seq_cnt_q == CNT_W'(SEQ_PERIOD-1));
    assign seq_cnt_d = seq_wrap ? '0 : seq_cnt_q + CNT_W'(1);

    // outputs trail seq_cnt by one cycle; seq_bit_q flips on the wrap and
    // seq_num_q follows it so seq_num changes together with the start pulse
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            seq_cnt_q <= '0;
            seq_bit_q <= 1'b0;
            start_q   <= 1'b0;
            ctx_num_q <= 1'b0;
            seq_num_q <= 1'b0;
        end else begin
            seq_cnt_q <= seq_cnt_d;
            if (seq_wrap) begin
                seq_bit_q <= ~seq_bit_q;
            end
            start_q   <= (seq_cnt_q < CNT_W'(2));
            ctx_num_q <= seq_cnt_q[0];
            seq_num_q <= seq_bit_q;
        end
    end

    assign start   = start_q;
    assign ctx_num = ctx_num_q;
    assign seq_num = seq_num_q;

    // ---------------- dispatcher FSM ----------------
    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] sel_core_q, sel_core_d;
    logic             sel_ctx_q, sel_ctx_d;
    logic             sel_seq_q, sel_seq_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             err_q, err_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_core;
    logic             pick_ctx, pick_seq;

    slot_rr_pick #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_pick (
        .core_ready_i (core_ready),
        .rr_ptr_i     (rr_ptr_q),
        .found_o      (pick_found),
        .core_o       (pick_core),
        .ctx_o        (pick_ctx),
        .seq_o        (pick_seq)
    );

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            sel_core_q <= '0;
            sel_ctx_q  <= 1'b0;
            sel_seq_q  <= 1'b0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_core_q <= sel_core_d;
            sel_ctx_q  <= sel_ctx_d;
            sel_seq_q  <= sel_seq_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sel_core_d   = sel_core_q;
        sel_ctx_d    = sel_ctx_q;
        sel_seq_d    = sel_seq_q;
        wcnt_d       = wcnt_q;
        err_d        = err_q;
        in_ready     = 1'b0;
        core_wr_en   = '0;
        core_din     = '0;
        core_wr_addr = '0;
        core_blk_op  = '0;
        core_ctx     = 1'b0;
        core_seq     = 1'b0;
        core_set_rdy = 1'b0;

        case (state_q)
            // one spare cycle lets the core's ready bits reflect the last write
            ST_IDLE: begin
                state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (pick_found) begin
                    sel_core_d = pick_core;
                    sel_ctx_d  = pick_ctx;
                    sel_seq_d  = pick_seq;
                    rr_ptr_d   = (pick_core == IDX_W'(N_CORES-1)) ? '0 : pick_core + IDX_W'(1);
                    wcnt_d     = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    core_wr_en[sel_core_q] = 1'b1;
                    core_din     = in_data;
                    core_wr_addr = wcnt_q;
                    core_ctx     = sel_ctx_q;
                    core_seq     = sel_seq_q;
                    wcnt_d       = wcnt_q + 4'd1;
                    // flagged only; the block still ends on word 15
                    if (in_last != (wcnt_q == 4'd15)) begin
                        err_d = 1'b1;
                    end
                    if (wcnt_q == 4'd15) begin
                        core_set_rdy = 1'b1;
                        core_blk_op  = in_blk_op;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err_framing = err_q;

    // ---------------- statistics ----------------
`ifdef SCHED_STAT_EN
    logic [31:0] stat_q;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (core_set_rdy) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_blocks = stat_q;
`else
    assign stat_blocks = 32'd0;
`endif

endmodule

// File: tb/tb_core_input_sched.sv
// tb/tb_core_input_sched.sv - self-checking bench for core_input_sched
module tb_core_input_sched;

    localparam int N  = 4;
    localparam int SP = 176;

    logic          CLK;
    logic          rst_n;
    logic          start, ctx_num, seq_num;
    logic          in_valid, in_ready, in_last;
    logic [63:0]   in_data;
    logic [1:0]    in_blk_op;
    logic [4*N-1:0] core_ready;
    logic [N-1:0]  core_wr_en;
    logic [63:0]   core_din;
    logic [3:0]    core_wr_addr;
    logic [1:0]    core_blk_op;
    logic          core_ctx, core_seq, core_set_rdy, err_framing;
    logic [31:0]   stat_blocks;

    core_input_sched #(.N_CORES(N), .SEQ_PERIOD(SP)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .start        (start),
        .ctx_num      (ctx_num),
        .seq_num      (seq_num),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_blk_op    (in_blk_op),
        .in_last      (in_last),
        .core_ready   (core_ready),
        .core_wr_en   (core_wr_en),
        .core_din     (core_din),
        .core_wr_addr (core_wr_addr),
        .core_blk_op  (core_blk_op),
        .core_ctx     (core_ctx),
        .core_seq     (core_seq),
        .core_set_rdy (core_set_rdy),
        .err_framing  (err_framing),
        .stat_blocks  (stat_blocks)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_ptr;
    int m_blocks;

    // observations gathered by send_block
    logic [63:0] sent [16];
    int          o_core, o_slot, o_tgt, o_addr_ok, o_din_ok, o_spur, o_t0, o_t15;
    logic [15:0] o_set;
    logic [1:0]  o_op;
    bit          timeout;

    function automatic int onehot_idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // first core from ptr (mod N) owning a free slot; lowest {ctx,seq} inside it
    function automatic int ref_pick(input logic [4*N-1:0] rdy, input int ptr, output int slot);
        slot = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            for (int s = 0; s < 4; s++) begin
                if (rdy[4*c+s]) begin
                    slot = s;
                    return c;
                end
            end
        end
        return -1;
    endfunction

    function automatic int exp_stat();
`ifdef SCHED_STAT_EN
        return m_blocks;
`else
        return 0;
`endif
    endfunction

    // gap_kind: 0 none, 1 random 0..2 idle cycles between words, 2 pattern 1,0,0,1 before word 5
    // the emulated core clears its slot's ready bit on the first write
    task automatic send_block(input int gap_kind, input int last_word, input logic [1:0] op);
        int w, waitc, gaps, c, s;
        w = 0; waitc = 0; gaps = 0; timeout = 0;
        o_core = -2; o_slot = -2; o_addr_ok = 0; o_din_ok = 0; o_spur = 0;
        o_set = '0; o_op = '0; o_t0 = 0; o_t15 = 0;
        for (int i = 0; i < 16; i++) sent[i] = {$urandom, $urandom};
        while (w < 16 && !timeout) begin
            @(negedge CLK);
            in_valid  = (gaps == 0);
            in_data   = in_valid ? sent[w] : {$urandom, $urandom};
            in_last   = in_valid && (w == last_word);
            in_blk_op = (w == 15) ? op : 2'($urandom);
            #1;
            if (in_valid && in_ready) begin
                c = onehot_idx(core_wr_en);
                s = int'({core_ctx, core_seq});
                if (w == 0) begin
                    o_core = c; o_slot = s; o_t0 = cyc;
                    if (c >= 0) core_ready[4*c+s] = 1'b0;
                end else if (c != o_core || s != o_slot) begin
                    o_core = -1;
                end
                if (core_wr_addr == 4'(w)) o_addr_ok++;
                if (core_din == sent[w]) o_din_ok++;
                o_set[w] = core_set_rdy;
                if (w == 15) begin
                    o_op = core_blk_op; o_t15 = cyc;
                end
                w++;
                waitc = 0;
                gaps = (gap_kind == 1) ? int'($urandom_range(0, 2)) : (gap_kind == 2 && w == 5) ? 2 : 0;
            end else begin
                if (core_wr_en != '0 || core_set_rdy) o_spur++;
                if (gaps > 0) gaps--;
                else begin
                    waitc++;
                    if (waitc > 100) timeout = 1;
                end
            end
        end
        o_tgt = (o_core < 0) ? -1 : o_core * 4 + o_slot;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        bit es, ec, eq;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_blk_op = '0; core_ready = '0;
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if ({start, ctx_num, seq_num, in_ready, core_wr_en, core_din, core_wr_addr, core_blk_op,
             core_ctx, core_seq, core_set_rdy, err_framing, stat_blocks} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got start=%b ctx=%b seq=%b rdy=%b wr_en=%b set=%b err=%b stat=%0d want all 0",
                     start, ctx_num, seq_num, in_ready, core_wr_en, core_set_rdy, err_framing, stat_blocks);
        end
        @(negedge CLK);
        rst_n = 1'b1; in_valid = 1'b1;
        m_ptr = 0; m_blocks = 0;
        for (int n = 1; n <= 180; n++) begin
            @(posedge CLK); #1;
            es = (((n - 1) % SP) < 2);
            ec = ((n - 1) % 2) == 1;
            eq = (n >= SP + 1);
            n_vec++;
            if ({start, ctx_num, seq_num} !== {es, ec, eq}) begin
                n_err++;
                $display("FAIL sync cycle %0d: got start/ctx/seq=%b%b%b want %b%b%b", n, start, ctx_num, seq_num, es, ec, eq);
            end
            n_vec++;
            if ({in_ready, core_wr_en} !== '0) begin
                n_err++;
                $display("FAIL no_slot_hold cycle %0d: got in_ready=%b wr_en=%b want 0", n, in_ready, core_wr_en);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ec, es, prev_t0;
        logic [1:0] op;
        core_ready = '1;
        prev_t0 = 0;
        for (int b = 0; b < 4; b++) begin
            ec = ref_pick(core_ready, m_ptr, es);
            op = 2'($urandom);
            send_block(0, 15, op);
            if (ec >= 0) begin m_ptr = (ec + 1) % N; m_blocks++; end
            n_vec++; if (o_tgt !== ec * 4 + es) begin n_err++; $display("FAIL b2b_target blk %0d: got %0d want %0d", b, o_tgt, ec * 4 + es); end
            n_vec++; if (o_addr_ok !== 16) begin n_err++; $display("FAIL b2b_addr blk %0d: got %0d ok want 16", b, o_addr_ok); end
            n_vec++; if (o_din_ok !== 16) begin n_err++; $display("FAIL b2b_din blk %0d: got %0d ok want 16", b, o_din_ok); end
            n_vec++; if (o_set !== 16'h8000) begin n_err++; $display("FAIL b2b_set_rdy blk %0d: got %h want 8000", b, o_set); end
            n_vec++; if (o_op !== op) begin n_err++; $display("FAIL b2b_blk_op blk %0d: got %0d want %0d", b, o_op, op); end
            if (b > 0) begin
                n_vec++; if (o_t0 - prev_t0 !== 18) begin n_err++; $display("FAIL b2b_period blk %0d: got %0d want 18", b, o_t0 - prev_t0); end
            end
            prev_t0 = o_t0;
        end
        n_vec++; if (stat_blocks !== 32'(exp_stat())) begin n_err++; $display("FAIL b2b_stat: got %0d want %0d", stat_blocks, exp_stat()); end
    endtask

    task automatic test_single_core();
        int ec, es;
        logic [1:0] op;
        core_ready = '0;
        core_ready[4*2+3] = 1'b1;
        ec = ref_pick(core_ready, m_ptr, es);
        op = 2'($urandom);
        send_block(0, 15, op);
        if (ec >= 0) begin m_ptr = (ec + 1) % N; m_blocks++; end
        n_vec++; if (o_tgt !== ec * 4 + es) begin n_err++; $display("FAIL single_target: got %0d want %0d", o_tgt, ec * 4 + es); end
        n_vec++; if (o_set !== 16'h8000) begin n_err++; $display("FAIL single_set_rdy: got %h want 8000", o_set); end
        n_vec++; if (o_din_ok !== 16) begin n_err++; $display("FAIL single_din: got %0d ok want 16", o_din_ok); end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            in_valid = 1'b1; in_data = {$urandom, $urandom};
            #1;
            n_vec++;
            if ({in_ready, core_wr_en} !== '0) begin
                n_err++;
                $display("FAIL select_hold cycle %0d: got in_ready=%b wr_en=%b want 0", i, in_ready, core_wr_en);
            end
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_gaps();
        int ec, es;
        logic [1:0] op;
        for (int b = 0; b < 6; b++) begin
            core_ready = 16'($urandom);
            if (core_ready == '0) core_ready[$urandom_range(0, 15)] = 1'b1;
            ec = ref_pick(core_ready, m_ptr, es);
            op = 2'($urandom);
            send_block((b == 0) ? 2 : 1, 15, op);
            if (ec >= 0) begin m_ptr = (ec + 1) % N; m_blocks++; end
            n_vec++; if (o_tgt !== ec * 4 + es) begin n_err++; $display("FAIL gap_target blk %0d: got %0d want %0d", b, o_tgt, ec * 4 + es); end
            n_vec++; if (o_addr_ok !== 16) begin n_err++; $display("FAIL gap_addr blk %0d: got %0d ok want 16", b, o_addr_ok); end
            n_vec++; if (o_din_ok !== 16) begin n_err++; $display("FAIL gap_din blk %0d: got %0d ok want 16", b, o_din_ok); end
            n_vec++; if (o_spur !== 0) begin n_err++; $display("FAIL gap_spurious blk %0d: got %0d want 0", b, o_spur); end
            n_vec++; if (o_set !== 16'h8000) begin n_err++; $display("FAIL gap_set_rdy blk %0d: got %h want 8000", b, o_set); end
            n_vec++; if (o_op !== op) begin n_err++; $display("FAIL gap_blk_op blk %0d: got %0d want %0d", b, o_op, op); end
        end
        n_vec++; if (err_framing !== 1'b0) begin n_err++; $display("FAIL gap_no_framing: got %b want 0", err_framing); end
    endtask

    task automatic test_framing();
        int ec, es;
        logic [1:0] op;
        for (int b = 0; b < 2; b++) begin
            core_ready = '1;
            ec = ref_pick(core_ready, m_ptr, es);
            op = 2'($urandom);
            send_block(0, (b == 0) ? 7 : 15, op);
            if (ec >= 0) begin m_ptr = (ec + 1) % N; m_blocks++; end
            n_vec++; if (o_tgt !== ec * 4 + es) begin n_err++; $display("FAIL frame_target blk %0d: got %0d want %0d", b, o_tgt, ec * 4 + es); end
            n_vec++; if (o_addr_ok !== 16) begin n_err++; $display("FAIL frame_addr blk %0d: got %0d ok want 16", b, o_addr_ok); end
            n_vec++; if (o_set !== 16'h8000) begin n_err++; $display("FAIL frame_set_rdy blk %0d: got %h want 8000", b, o_set); end
            n_vec++; if (err_framing !== 1'b1) begin n_err++; $display("FAIL frame_sticky blk %0d: got %b want 1", b, err_framing); end
        end
    endtask

    task automatic test_reset_mid_load();
        int ec, es, w, waitc;
        core_ready = '0;
        core_ready[7:4] = 4'hF;
        ec = ref_pick(core_ready, m_ptr, es);
        if (ec >= 0) m_ptr = (ec + 1) % N;
        w = 0; waitc = 0;
        while (w < 9 && waitc < 100) begin
            @(negedge CLK);
            in_valid = 1'b1; in_last = 1'b0; in_data = {$urandom, $urandom};
            #1;
            if (in_ready) begin
                if (w == 0 && onehot_idx(core_wr_en) >= 0)
                    core_ready[4*onehot_idx(core_wr_en) + int'({core_ctx, core_seq})] = 1'b0;
                w++;
            end else waitc++;
        end
        n_vec++; if (w !== 9) begin n_err++; $display("FAIL rst_mid_words: got %0d want 9", w); end
        @(negedge CLK);
        rst_n = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom};
        @(posedge CLK); #1;
        n_vec++;
        if ({start, ctx_num, seq_num, in_ready, core_wr_en, core_din, core_wr_addr, core_blk_op,
             core_ctx, core_seq, core_set_rdy, err_framing, stat_blocks} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got start=%b rdy=%b wr_en=%b set=%b err=%b stat=%0d want all 0",
                     start, in_ready, core_wr_en, core_set_rdy, err_framing, stat_blocks);
        end
        @(negedge CLK);
        rst_n = 1'b1; in_valid = 1'b0;
        m_ptr = 0; m_blocks = 0;
        core_ready = 16'hFFFF;
        core_ready[4*1+0] = 1'b0;
        ec = ref_pick(core_ready, m_ptr, es);
        send_block(0, 15, 2'd3);
        if (ec >= 0) begin m_ptr = (ec + 1) % N; m_blocks++; end
        n_vec++; if (o_tgt !== ec * 4 + es) begin n_err++; $display("FAIL rst_reselect: got %0d want %0d", o_tgt, ec * 4 + es); end
        n_vec++; if (o_set !== 16'h8000) begin n_err++; $display("FAIL rst_set_rdy: got %h want 8000", o_set); end
        n_vec++; if (err_framing !== 1'b0) begin n_err++; $display("FAIL rst_err_clear: got %b want 0", err_framing); end
        n_vec++; if (stat_blocks !== 32'(exp_stat())) begin n_err++; $display("FAIL rst_stat: got %0d want %0d", stat_blocks, exp_stat()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_single_core();
        test_gaps();
        test_framing();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
